if_prefetch_stage: RTL

Parametrised instruction-fetch stage with a decoupled instruction-memory request/response port, a prefetch queue of DEPTH entries, and branch redirect with flush of queued and in-flight fetches. Sits between the PC/instruction memory and the ID stage, replacing the single-cycle fetch path. Instructions reach ID tagged with their PC, and freez back-pressure is absorbed by the queue instead of re-fetching.

---
 rtl/if_prefetch_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage: decoupled imem request/response port feeding a DEPTH-entry
// prefetch queue of {pc, instr} pairs, with branch redirect that flushes queued and in-flight fetches.
module if_prefetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit              BR_ABS   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freez,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_offset,
    input  logic [XLEN-1:0] br_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instruction
);

    localparam int unsigned QAddrW = $clog2(DEPTH);
    localparam int unsigned QCntW  = $clog2(DEPTH + 1);
    localparam int unsigned OCntW  = $clog2(MAX_OUT + 1);
    localparam int unsigned TagW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CredW  = ((QCntW > OCntW) ? QCntW : OCntW) + 1;
    localparam logic [XLEN-1:0] PcStep = XLEN'(XLEN / 8);

    logic              active_q;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   q_pc_q    [DEPTH];
    logic [XLEN-1:0]   q_instr_q [DEPTH];
    logic [QAddrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [QCntW-1:0]  count_q, count_d;
    logic [OCntW-1:0]  outst_q, outst_d, drop_q, drop_d;
    logic [XLEN-1:0]   tag_q [MAX_OUT];
    logic [TagW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CredW-1:0]  credits;
    logic [XLEN-1:0]   br_target;
    logic              issue, keep, pop;

    function automatic logic [TagW-1:0] tag_inc(input logic [TagW-1:0] p);
        return (p == TagW'(MAX_OUT - 1)) ? '0 : p + TagW'(1);
    endfunction

    // Slots already committed: queued entries plus live (non-dropped) fetches in flight.
    assign credits        = CredW'(count_q) + CredW'(outst_q) - CredW'(drop_q);
    assign imem_req_valid = active_q && !br_taken && (outst_q < OCntW'(MAX_OUT))
                            && (credits < CredW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign keep           = imem_rsp_valid && !br_taken && (drop_q == '0);
    assign out_valid      = (count_q != '0);
    assign pop            = out_valid && !freez && !br_taken;
    assign pc             = out_valid ? q_pc_q[rd_ptr_q] : '0;
    assign instruction    = out_valid ? q_instr_q[rd_ptr_q] : '0;
    assign br_target      = BR_ABS ? br_offset : (br_pc + PcStep + (br_offset << 2));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        drop_d     = drop_q;
        tag_wr_d   = issue ? tag_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d   = imem_rsp_valid ? tag_inc(tag_rd_q) : tag_rd_q;
        outst_d    = outst_q + OCntW'(issue) - OCntW'(imem_rsp_valid);
        if (br_taken) begin
            fetch_pc_d = br_target;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            // Every fetch still in flight after this cycle is stale, including ones already
            // marked for dropping, so this stays correct when br_taken is held.
            drop_d     = outst_q - OCntW'(imem_rsp_valid);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + PcStep;
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - OCntW'(1);
            if (keep) wr_ptr_d = wr_ptr_q + QAddrW'(1);
            if (pop) rd_ptr_d = rd_ptr_q + QAddrW'(1);
            count_d = count_q + QCntW'(keep) - QCntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q   <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
        end else begin
            active_q   <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (issue) tag_q[tag_wr_q] <= fetch_pc_q;
        if (keep) begin
            q_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
            q_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule
